// File: rtl/kmeans_centroid_update_if.sv
// rtl/kmeans_centroid_update_if.sv - sample stream, centroid buses and status of the centroid-update engine
interface kmeans_centroid_update_if #(
   parameter int input_data_width         = 8,
   parameter int input_data_qty_bit_width = 8,
   parameter int centroids_qty            = 2,
   parameter int centroid_idx_width       = 1,
   parameter int dimensions_qty           = 2
);
   localparam int AllW = centroids_qty * dimensions_qty * input_data_width;

   logic                                         clear;
   logic                                         in_valid;
   logic [centroid_idx_width-1:0]                in_centroid;
   logic [dimensions_qty*input_data_width-1:0]   in_data;
   logic                                         in_last;
   logic [AllW-1:0]                              prev_centroids;
   logic [AllW-1:0]                              out_centroids;
   logic                                         out_valid;
   logic                                         changed;
   logic                                         busy;
   logic                                         overflow;

   modport master (
      output clear, in_valid, in_centroid, in_data, in_last, prev_centroids,
      input  out_centroids, out_valid, changed, busy, overflow
   );

   modport slave (
      input  clear, in_valid, in_centroid, in_data, in_last, prev_centroids,
      output out_centroids, out_valid, changed, busy, overflow
   );
endinterface

// File: rtl/kmeans_centroid_update.sv
// rtl/kmeans_centroid_update.sv - per-centroid accumulation and floor-mean centroid recompute
module kmeans_centroid_update #(
   parameter int input_data_width         = 8,
   parameter int input_data_qty_bit_width = 8,
   parameter int centroids_qty            = 2,
   parameter int centroid_idx_width       = 1,
   parameter int dimensions_qty           = 2
) (
   input logic                      clk,
   input logic                      rst,
   kmeans_centroid_update_if.slave  kif
);
   localparam int W     = input_data_width;
   localparam int CntW  = input_data_qty_bit_width + 1;
   localparam int SumW  = input_data_width + input_data_qty_bit_width;
   localparam int Elems = centroids_qty * dimensions_qty;
   localparam int StepW = $clog2(SumW + 1);
   localparam int EW    = $clog2(Elems);
   localparam int DW    = (dimensions_qty > 1) ? $clog2(dimensions_qty) : 1;
   localparam logic [CntW-1:0] Cap = {1'b1, {input_data_qty_bit_width{1'b0}}};

   typedef enum logic [1:0] {ACC, DIV, DONE} state_t;

   state_t                        state_q, state_d;
   logic [SumW-1:0]               sum_q [Elems];
   logic [CntW-1:0]               cnt_q [centroids_qty];
   logic [CntW-1:0]               total_q;
   logic                          ovf_q;
   logic [centroid_idx_width-1:0] k_q;
   logic [DW-1:0]                 d_q;
   logic [EW-1:0]                 e_q;
   logic [StepW-1:0]              step_q;
   logic [SumW-1:0]               dv_q;
   logic [CntW-1:0]               rem_q;
   logic [CntW-1:0]               den_q;
   logic [W-1:0]                  prev_el_q;
   logic                          chg_q;
   logic [W-1:0]                  res_q [Elems];
   logic [Elems*W-1:0]            out_q;
   logic                          out_valid_q;
   logic                          changed_q;

   logic                          accept, rejected;
   logic                          last_step, last_elem;
   logic [CntW:0]                 trial;
   logic                          fits;
   logic [CntW-1:0]               rem_next;
   logic [SumW-1:0]               dv_next;
   logic [W-1:0]                  elem_res;

   // Restoring division: the quotient bits shift into the dividend register as its bits shift out.
   assign last_step = (step_q == StepW'(SumW));
   assign last_elem = (e_q == EW'(Elems - 1));
   assign trial     = {rem_q, dv_q[SumW-1]};
   assign fits      = (trial >= {1'b0, den_q});
   assign rem_next  = fits ? CntW'(trial - {1'b0, den_q}) : trial[CntW-1:0];
   assign dv_next   = {dv_q[SumW-2:0], fits};
   assign elem_res  = (den_q == '0) ? prev_el_q : dv_next[W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ACC;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      rejected = 1'b0;
      case (state_q)
         ACC: begin
            if (kif.in_valid) begin
               accept   = (total_q != Cap);
               rejected = (total_q == Cap);
               if (kif.in_last) state_d = DIV;
            end
         end
         DIV:     if (last_step && last_elem) state_d = DONE;
         DONE:    state_d = ACC;
         default: state_d = ACC;
      endcase
      if (kif.clear) begin
         state_d  = ACC;
         accept   = 1'b0;
         rejected = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < Elems; i++) begin
            sum_q[i] <= '0;
            res_q[i] <= '0;
         end
         for (int k = 0; k < centroids_qty; k++) cnt_q[k] <= '0;
         total_q     <= '0;
         ovf_q       <= 1'b0;
         k_q         <= '0;
         d_q         <= '0;
         e_q         <= '0;
         step_q      <= '0;
         dv_q        <= '0;
         rem_q       <= '0;
         den_q       <= '0;
         prev_el_q   <= '0;
         chg_q       <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         changed_q   <= 1'b0;
      end else if (kif.clear) begin
         for (int i = 0; i < Elems; i++) sum_q[i] <= '0;
         for (int k = 0; k < centroids_qty; k++) cnt_q[k] <= '0;
         total_q     <= '0;
         ovf_q       <= 1'b0;
         k_q         <= '0;
         d_q         <= '0;
         e_q         <= '0;
         step_q      <= '0;
         chg_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (rejected) ovf_q <= 1'b1;
         if (accept) begin
            total_q <= total_q + CntW'(1);
            for (int k = 0; k < centroids_qty; k++) begin
               if (kif.in_centroid == centroid_idx_width'(k)) begin
                  cnt_q[k] <= cnt_q[k] + CntW'(1);
                  for (int d = 0; d < dimensions_qty; d++)
                     sum_q[k*dimensions_qty+d] <= sum_q[k*dimensions_qty+d]
                                                + SumW'(kif.in_data[d*W +: W]);
               end
            end
         end
         if (state_q == DIV) begin
            if (step_q == '0) begin
               dv_q      <= sum_q[e_q];
               den_q     <= cnt_q[k_q];
               rem_q     <= '0;
               prev_el_q <= kif.prev_centroids[e_q*W +: W];
               step_q    <= StepW'(1);
            end else begin
               dv_q  <= dv_next;
               rem_q <= rem_next;
               if (last_step) begin
                  res_q[e_q] <= elem_res;
                  chg_q      <= chg_q | (elem_res != prev_el_q);
                  step_q     <= '0;
                  e_q        <= e_q + EW'(1);
                  if (d_q == DW'(dimensions_qty - 1)) begin
                     d_q <= '0;
                     k_q <= k_q + centroid_idx_width'(1);
                  end else begin
                     d_q <= d_q + DW'(1);
                  end
               end else begin
                  step_q <= step_q + StepW'(1);
               end
            end
         end
         if (state_q == DONE) begin
            for (int i = 0; i < Elems; i++) begin
               out_q[i*W +: W] <= res_q[i];
               sum_q[i]        <= '0;
            end
            for (int k = 0; k < centroids_qty; k++) cnt_q[k] <= '0;
            total_q     <= '0;
            changed_q   <= chg_q;
            chg_q       <= 1'b0;
            out_valid_q <= 1'b1;
            k_q         <= '0;
            d_q         <= '0;
            e_q         <= '0;
         end
      end
   end

   assign kif.out_centroids = out_q;
   assign kif.out_valid     = out_valid_q;
   assign kif.changed       = changed_q;
   assign kif.busy          = (state_q != ACC);
   assign kif.overflow      = ovf_q;
endmodule

// File: tb/tb_kmeans_centroid_update.sv
// tb/tb_kmeans_centroid_update.sv - scoreboard bench for kmeans_centroid_update, default and swept parameters
module tb_kmeans_centroid_update;
   localparam int AW = 8,  AN = 8, AK = 2, AC = 1, AD = 2;
   localparam int AL = AK * AD * (AW + AN + 1) + 1;
   localparam int BW = 12, BN = 6, BK = 4, BC = 2, BD = 3;
   localparam int BL = BK * BD * (BW + BN + 1) + 1;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   kmeans_centroid_update_if #(.input_data_width(AW), .input_data_qty_bit_width(AN),
      .centroids_qty(AK), .centroid_idx_width(AC), .dimensions_qty(AD)) ifa ();
   kmeans_centroid_update_if #(.input_data_width(BW), .input_data_qty_bit_width(BN),
      .centroids_qty(BK), .centroid_idx_width(BC), .dimensions_qty(BD)) ifb ();

   kmeans_centroid_update #(.input_data_width(AW), .input_data_qty_bit_width(AN),
      .centroids_qty(AK), .centroid_idx_width(AC), .dimensions_qty(AD))
      dut_a (.clk(clk), .rst(rst_a), .kif(ifa));
   kmeans_centroid_update #(.input_data_width(BW), .input_data_qty_bit_width(BN),
      .centroids_qty(BK), .centroid_idx_width(BC), .dimensions_qty(BD))
      dut_b (.clk(clk), .rst(rst_b), .kif(ifb));

   typedef struct { logic [AK*AD*AW-1:0] c; logic ch; int e0; } exp_a_t;
   typedef struct { logic [BK*BD*BW-1:0] c; logic ch; int e0; } exp_b_t;
   exp_a_t qa[$];
   exp_b_t qb[$];
   exp_a_t ea;
   exp_b_t eb;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: pop and compare on every out_valid.
   logic ov_a_prev = 1'b0, ov_b_prev = 1'b0;
   int   busy_a = 0, busy_b = 0;
   always @(negedge clk) begin
      if (rst_a || ifa.clear) busy_a = 0;
      else if (ifa.busy) busy_a++;
      if (ifa.out_valid) begin
         check("a_pulse_width", ov_a_prev, 1'b0);
         if (qa.size() == 0) begin
            check("a_unexpected_out_valid", 1'b1, 1'b0);
         end else if (!ov_a_prev) begin
            ea = qa.pop_front();
            check("a_centroids", ifa.out_centroids, ea.c);
            check("a_changed", ifa.changed, ea.ch);
            check("a_latency", cyc - ea.e0, AL);
            check("a_busy_cycles", busy_a, AL);
         end
         busy_a = 0;
      end
      ov_a_prev = ifa.out_valid;
   end

   always @(negedge clk) begin
      if (rst_b || ifb.clear) busy_b = 0;
      else if (ifb.busy) busy_b++;
      if (ifb.out_valid) begin
         check("b_pulse_width", ov_b_prev, 1'b0);
         if (qb.size() == 0) begin
            check("b_unexpected_out_valid", 1'b1, 1'b0);
         end else if (!ov_b_prev) begin
            eb = qb.pop_front();
            check("b_centroids", ifb.out_centroids, eb.c);
            check("b_changed", ifb.changed, eb.ch);
            check("b_latency", cyc - eb.e0, BL);
            check("b_busy_cycles", busy_b, BL);
         end
         busy_b = 0;
      end
      ov_b_prev = ifb.out_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input int k, input int x0, input int x1, input bit last);
      ifa.in_valid    = 1'b1;
      ifa.in_centroid = AC'(k);
      ifa.in_data     = {x1[AW-1:0], x0[AW-1:0]};
      ifa.in_last     = last;
      tick();
      ifa.in_valid = 1'b0;
      ifa.in_last  = 1'b0;
   endtask

   task automatic push_a(input logic [AK*AD*AW-1:0] c, input logic ch);
      exp_a_t e;
      e.c = c;
      e.ch = ch;
      e.e0 = cyc;
      qa.push_back(e);
   endtask

   task automatic wait_a();
      for (int i = 0; i < 4 * AL && qa.size() != 0; i++) tick();
      check("a_timeout_pending", qa.size(), 0);
      qa.delete();
   endtask

   task automatic pulse_clear_a();
      ifa.clear = 1'b1;
      tick();
      ifa.clear = 1'b0;
   endtask

   task automatic send_b(input int k, input logic [BD*BW-1:0] data, input bit last);
      ifb.in_valid    = 1'b1;
      ifb.in_centroid = BC'(k);
      ifb.in_data     = data;
      ifb.in_last     = last;
      tick();
      ifb.in_valid = 1'b0;
      ifb.in_last  = 1'b0;
   endtask

   // Floor-mean reference: clusters 0..2 receive samples, cluster 3 stays empty.
   task automatic run_b(input int nsamp);
      int sb [BK][BD];
      int cb [BK];
      logic [BK*BD*BW-1:0] prev, expv;
      logic [BD*BW-1:0] data;
      logic ch;
      int k, v, r;
      exp_b_t e;
      for (int i = 0; i < BK; i++) begin
         cb[i] = 0;
         for (int d = 0; d < BD; d++) begin
            sb[i][d] = 0;
            prev[(i*BD+d)*BW +: BW] = BW'($urandom_range(0, 4095));
         end
      end
      ifb.prev_centroids = prev;
      for (int n = 0; n < nsamp; n++) begin
         k = $urandom_range(0, 2);
         for (int d = 0; d < BD; d++) begin
            v = $urandom_range(0, 4095);
            data[d*BW +: BW] = BW'(v);
            sb[k][d] += v;
         end
         cb[k]++;
         send_b(k, data, n == nsamp - 1);
      end
      ch = 1'b0;
      for (int i = 0; i < BK; i++)
         for (int d = 0; d < BD; d++) begin
            r = (cb[i] == 0) ? int'(prev[(i*BD+d)*BW +: BW]) : sb[i][d] / cb[i];
            expv[(i*BD+d)*BW +: BW] = BW'(r);
            if (BW'(r) != prev[(i*BD+d)*BW +: BW]) ch = 1'b1;
         end
      e.c = expv;
      e.ch = ch;
      e.e0 = cyc;
      qb.push_back(e);
      for (int i = 0; i < 4 * BL && qb.size() != 0; i++) tick();
      check("b_timeout_pending", qb.size(), 0);
      qb.delete();
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      ifa.clear = 1'b0; ifa.in_valid = 1'b0; ifa.in_centroid = '0; ifa.in_data = '0;
      ifa.in_last = 1'b0; ifa.prev_centroids = '0;
      ifb.clear = 1'b0; ifb.in_valid = 1'b0; ifb.in_centroid = '0; ifb.in_data = '0;
      ifb.in_last = 1'b0; ifb.prev_centroids = '0;
      repeat (3) tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick();
      check("rst_out_centroids", ifa.out_centroids, 0);
      check("rst_out_valid", ifa.out_valid, 0);
      check("rst_changed", ifa.changed, 0);
      check("rst_busy", ifa.busy, 0);
      check("rst_overflow", ifa.overflow, 0);

      // Basic: k0 mean (1,1), k1 mean (12,22).
      ifa.prev_centroids = {8'd1, 8'd1, 8'd0, 8'd0};
      send_a(0, 0, 0, 0);
      send_a(0, 2, 2, 0);
      send_a(1, 10, 20, 0);
      send_a(1, 12, 22, 0);
      send_a(1, 14, 24, 1);
      push_a({8'd22, 8'd12, 8'd1, 8'd1}, 1'b1);
      wait_a();
      repeat (5) tick();
      check("basic_held_centroids", ifa.out_centroids, {8'd22, 8'd12, 8'd1, 8'd1});
      check("basic_busy_low", ifa.busy, 0);

      // Floor and empty cluster.
      ifa.prev_centroids = {8'd7, 8'd5, 8'd3, 8'd1};
      send_a(0, 1, 3, 0);
      send_a(0, 2, 4, 1);
      push_a({8'd7, 8'd5, 8'd3, 8'd1}, 1'b0);
      wait_a();

      // Samples offered while busy must be dropped.
      ifa.prev_centroids = '0;
      send_a(0, 4, 4, 0);
      send_a(1, 8, 8, 1);
      push_a({8'd8, 8'd8, 8'd4, 8'd4}, 1'b1);
      for (int i = 0; i < 30; i++) send_a(0, 200, 200, i[0]);
      wait_a();
      ifa.prev_centroids = {8'd3, 8'd3, 8'd0, 8'd0};
      send_a(0, 10, 10, 1);
      push_a({8'd3, 8'd3, 8'd10, 8'd10}, 1'b1);
      wait_a();
      check("busy_drop_no_overflow", ifa.overflow, 0);

      // Clear mid-division aborts the iteration without publishing.
      send_a(0, 50, 50, 0);
      send_a(1, 60, 60, 1);
      repeat (20) tick();
      pulse_clear_a();
      repeat (AL + 10) tick();
      check("clear_keeps_centroids", ifa.out_centroids, {8'd3, 8'd3, 8'd10, 8'd10});
      check("clear_busy_low", ifa.busy, 0);
      ifa.prev_centroids = '0;
      send_a(0, 6, 7, 0);
      send_a(1, 9, 8, 1);
      push_a({8'd8, 8'd9, 8'd7, 8'd6}, 1'b1);
      wait_a();

      // Capacity: 257th sample rejected but its in_last still starts the division.
      ifa.prev_centroids = {8'd9, 8'd9, 8'd0, 8'd0};
      for (int i = 0; i < 257; i++) send_a(0, 255, 255, i == 256);
      push_a({8'd9, 8'd9, 8'd255, 8'd255}, 1'b1);
      wait_a();
      check("capacity_overflow_set", ifa.overflow, 1);
      pulse_clear_a();
      check("capacity_overflow_cleared", ifa.overflow, 0);
      check("capacity_clear_keeps_centroids", ifa.out_centroids, {8'd9, 8'd9, 8'd255, 8'd255});

      // Asynchronous reset in the middle of a division.
      ifa.prev_centroids = '0;
      send_a(0, 100, 100, 0);
      send_a(1, 50, 50, 1);
      repeat (10) tick();
      rst_a = 1'b1;
      #2;
      check("midrst_out_centroids", ifa.out_centroids, 0);
      check("midrst_out_valid", ifa.out_valid, 0);
      check("midrst_changed", ifa.changed, 0);
      check("midrst_busy", ifa.busy, 0);
      check("midrst_overflow", ifa.overflow, 0);
      tick();
      rst_a = 1'b0;
      tick();
      ifa.prev_centroids = {8'd1, 8'd2, 8'd3, 8'd4};
      send_a(0, 3, 4, 0);
      send_a(0, 5, 6, 0);
      send_a(1, 7, 7, 1);
      push_a({8'd7, 8'd7, 8'd5, 8'd4}, 1'b1);
      wait_a();

      // Parameter sweep instance.
      run_b(20);
      run_b(64);
      check("b_no_overflow_at_capacity", ifb.overflow, 0);

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
